pwd_lock_ctrl: RTL and testbench

PWD_LOCK_CTRL -- requirements
Module: pwd_lock_ctrl

---
 rtl/pwd_lock_ctrl.sv | 83 ++++++++
 tb/tb_pwd_lock_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_lock_ctrl.sv
// pwd_lock_ctrl: 4-digit keypad lock with timed pass/fail indication and lockout.
// The pass/fail/locked flags are registered from the state, so they trail it by one cycle.
module pwd_lock_ctrl #(
   parameter logic [15:0] PWD      = 16'h1234,
   parameter int          N_TRY    = 3,
   parameter int          HOLD     = 8,
   parameter int          LOCK_CYC = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       key_vld,
   input  logic [3:0] key_in,
   input  logic       clr,
   input  logic       admin_unlock,
   output logic       unlocked,
   output logic       fail,
   output logic       locked,
   output logic [2:0] digit_cnt,
   output logic [1:0] attempts_left
);
   localparam int TW = $clog2((HOLD > LOCK_CYC ? HOLD : LOCK_CYC) + 1);
   localparam logic [1:0] NT = 2'(N_TRY);
   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, PASS, FAIL, LOCK} state_t;
   state_t state;
   logic [15:0] entry;
   logic [TW-1:0] tmr;
   logic [1:0] fail_cnt, fc_inc;
   assign fc_inc = (fail_cnt == NT) ? NT : fail_cnt + 2'd1;
   assign attempts_left = NT - fail_cnt;
   always_ff @(posedge clk)
      if (!rstn) begin
         state <= IDLE;
         entry <= '0;
         tmr <= '0;
         fail_cnt <= '0;
         digit_cnt <= '0;
         unlocked <= 1'b0;
         fail <= 1'b0;
         locked <= 1'b0;
      end else begin
         unlocked <= state == PASS;
         fail <= state == FAIL;
         locked <= state == LOCK && !admin_unlock;
         case (state)
            IDLE:
               if (key_vld) begin
                  entry <= {entry[11:0], key_in};
                  digit_cnt <= 3'd1;
                  state <= ENTRY;
               end
            ENTRY:
               if (clr) begin
                  digit_cnt <= 3'd0;
                  state <= IDLE;
               end else if (key_vld) begin
                  entry <= {entry[11:0], key_in};
                  digit_cnt <= digit_cnt + 3'd1;
                  if (digit_cnt == 3'd3) state <= CHECK;
               end
            CHECK: begin
               digit_cnt <= 3'd0;
               if (entry == PWD) begin
                  fail_cnt <= 2'd0;
                  tmr <= TW'(HOLD - 1);
                  state <= PASS;
               end else begin
                  fail_cnt <= fc_inc;
                  tmr <= (fc_inc == NT) ? TW'(LOCK_CYC - 1) : TW'(HOLD - 1);
                  state <= (fc_inc == NT) ? LOCK : FAIL;
               end
            end
            PASS, FAIL:
               if (tmr == '0) state <= IDLE;
               else tmr <= tmr - TW'(1);
            LOCK:
               if (admin_unlock || tmr == '0) begin
                  fail_cnt <= 2'd0;
                  state <= IDLE;
               end else tmr <= tmr - TW'(1);
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// tb_pwd_lock_ctrl: directed scenarios plus randomized traffic against a digit-queue reference model.
module tb_pwd_lock_ctrl;
   localparam logic [15:0] PWD = 16'h1234;
   localparam int N_TRY = 3, HOLD = 8, LOCK_CYC = 64;
   localparam logic [7:0] NOP = 8'b1_0_0000_0_0, RST = 8'b0_0_0000_0_0;
   localparam logic [7:0] CLR = 8'b1_0_0000_1_0, ADM = 8'b1_0_0000_0_1;
   localparam logic [7:0] IDLE_V = {3'b000, 3'd0, 2'd3};

   logic clk = 1'b0, rstn = 1'b0, key_vld = 1'b0, clr = 1'b0, admin_unlock = 1'b0;
   logic [3:0] key_in = 4'd0;
   logic unlocked, fail, locked;
   logic [2:0] digit_cnt;
   logic [1:0] attempts_left;
   logic [7:0] dut_v, exp_v = 8'd0;
   int n_cmp = 0, n_err = 0;
   logic [7:0] seq[$];

   pwd_lock_ctrl #(.PWD(PWD), .N_TRY(N_TRY), .HOLD(HOLD), .LOCK_CYC(LOCK_CYC)) dut (
      .clk(clk), .rstn(rstn), .key_vld(key_vld), .key_in(key_in), .clr(clr),
      .admin_unlock(admin_unlock), .unlocked(unlocked), .fail(fail), .locked(locked),
      .digit_cnt(digit_cnt), .attempts_left(attempts_left));

   always #5 clk = ~clk;
   assign dut_v = {unlocked, fail, locked, digit_cnt, attempts_left};

   // Reference model: digits typed so far, a phase with its remaining length, and the failure tally.
   // Phases: 0 collecting digits, 1 checking, 2 pass, 3 fail, 4 lockout. Flags show the previous phase.
   logic [3:0] digs[$];
   int phase = 0, left = 0, fails = 0, m_dcnt = 0;
   logic m_unl = 1'b0, m_fail = 1'b0, m_lock = 1'b0;
   always @(posedge clk) begin
      if (!rstn) begin
         digs.delete();
         phase = 0; left = 0; fails = 0;
         m_unl = 1'b0; m_fail = 1'b0; m_lock = 1'b0;
      end else begin
         m_unl = phase == 2;
         m_fail = phase == 3;
         m_lock = phase == 4 && !admin_unlock;
         if (phase == 0) begin
            if (clr && digs.size() > 0) digs.delete();
            else if (key_vld) begin
               digs.push_back(key_in);
               if (digs.size() == 4) phase = 1;
            end
         end else if (phase == 1) begin
            if ({digs[0], digs[1], digs[2], digs[3]} == PWD) begin
               fails = 0; phase = 2; left = HOLD;
            end else begin
               if (fails < N_TRY) fails++;
               phase = (fails == N_TRY) ? 4 : 3;
               left = (fails == N_TRY) ? LOCK_CYC : HOLD;
            end
            digs.delete();
         end else if (phase == 2 || phase == 3) begin
            left--;
            if (left == 0) phase = 0;
         end else begin
            left--;
            if (admin_unlock || left == 0) begin phase = 0; fails = 0; end
         end
      end
      m_dcnt = phase == 1 ? 4 : (phase == 0 ? digs.size() : 0);
      exp_v = {m_unl, m_fail, m_lock, 3'(m_dcnt), 2'(N_TRY - fails)};
   end

   function automatic logic [7:0] k(input logic [3:0] d);
      return {2'b11, d, 2'b00};
   endfunction

   task automatic step(input logic [7:0] s);
      {rstn, key_vld, key_in, clr, admin_unlock} = s;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add_keys(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) seq.push_back(k(code[4*i +: 4]));
   endtask

   task automatic add_n(input logic [7:0] s, input int n);
      repeat (n) seq.push_back(s);
   endtask

   task automatic test_reset;
      seq.delete();
      add_n(RST, 2);
      seq.push_back(8'b0_1_0001_0_0);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== IDLE_V || exp_v !== IDLE_V) begin
            n_err++;
            $display("FAIL reset[%0d]: dut=%b model=%b required=%b", i, dut_v, exp_v, IDLE_V);
         end
      end
   endtask

   task automatic test_pass;
      int hi = 0, first = -1;
      seq.delete();
      add_keys(16'h1234);
      add_n(NOP, 12);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL pass[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (unlocked === 1'b1) begin hi++; if (first < 0) first = i; end
      end
      n_cmp++;
      if (hi != HOLD || first != 5) begin
         n_err++;
         $display("FAIL pass_window: got %0d cycles from step %0d, required 8 from step 5", hi, first);
      end
   endtask

   task automatic test_lockout;
      int fhi = 0, lhi = 0;
      logic [1:0] att1 = 2'd0, att2 = 2'd0;
      seq.delete();
      add_keys(16'h1235); add_n(NOP, 10);
      add_keys(16'h1235); add_n(NOP, 10);
      add_keys(16'h1235); add_n(NOP, 72);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL lockout[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (fail === 1'b1) fhi++;
         if (locked === 1'b1) lhi++;
         if (i == 5) att1 = attempts_left;
         if (i == 19) att2 = attempts_left;
      end
      n_cmp++;
      if (fhi != 16 || lhi != 64) begin
         n_err++;
         $display("FAIL lockout_len: fail %0d locked %0d cycles, required 16 and 64", fhi, lhi);
      end
      n_cmp++;
      if (att1 !== 2'd2 || att2 !== 2'd1 || attempts_left !== 2'd3) begin
         n_err++;
         $display("FAIL lockout_att: got %0d,%0d,%0d required 2,1,3", att1, att2, attempts_left);
      end
   endtask

   task automatic test_clear;
      int hi = 0;
      seq.delete();
      seq.push_back(k(4'd1)); seq.push_back(k(4'd2));
      seq.push_back(8'b1_1_0011_1_0);
      add_keys(16'h1234);
      add_n(NOP, 12);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL clear[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (i == 2) begin
            n_cmp++;
            if (dut_v !== IDLE_V) begin n_err++; $display("FAIL clear_prio: dut=%b required=%b", dut_v, IDLE_V); end
         end
         if (unlocked === 1'b1) hi++;
      end
      n_cmp++;
      if (hi != HOLD) begin n_err++; $display("FAIL clear_unlock: %0d cycles, required 8", hi); end
   endtask

   task automatic test_admin;
      seq.delete();
      add_keys(16'h9999); add_n(NOP, 10);
      add_keys(16'h9999); add_n(NOP, 10);
      add_keys(16'h9999); add_n(NOP, 10);
      seq.push_back(ADM);
      add_n(NOP, 3); add_n(ADM, 2); add_n(NOP, 2);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL admin[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (i == 41 || i == 42 || i >= 46) begin
            n_cmp++;
            if (dut_v !== (i == 41 ? {3'b001, 3'd0, 2'd0} : IDLE_V)) begin
               n_err++;
               $display("FAIL admin_state[%0d]: dut=%b", i, dut_v);
            end
         end
      end
   endtask

   task automatic test_ignored;
      seq.delete();
      add_keys(16'h1234);
      add_n(NOP, 2); add_n(k(4'd9), 4); seq.push_back(CLR); add_n(NOP, 4);
      seq.push_back(k(4'd1)); seq.push_back(k(4'd2)); seq.push_back(k(4'd3));
      seq.push_back(RST); seq.push_back(NOP);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL ignored[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (i >= 6 && i <= 10) begin
            n_cmp++;
            if (digit_cnt !== 3'd0 || unlocked !== 1'b1) begin
               n_err++;
               $display("FAIL ignored_pass[%0d]: digit_cnt=%0d unlocked=%b required 0,1", i, digit_cnt, unlocked);
            end
         end
         if (i >= 18) begin
            n_cmp++;
            if (dut_v !== IDLE_V) begin n_err++; $display("FAIL mid_entry_reset[%0d]: dut=%b required=%b", i, dut_v, IDLE_V); end
         end
      end
   endtask

   task automatic test_fail_then_pass;
      seq.delete();
      add_keys(16'h4321); add_n(NOP, 10);
      add_keys(16'h1234); add_n(NOP, 12);
      foreach (seq[i]) begin
         step(seq[i]);
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL retry[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         if (i == 5 || i == 19) begin
            n_cmp++;
            if (dut_v !== (i == 5 ? {3'b010, 3'd0, 2'd2} : {3'b100, 3'd0, 2'd3})) begin
               n_err++;
               $display("FAIL retry_att[%0d]: dut=%b", i, dut_v);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] pw = PWD;
      logic [3:0] d;
      for (int i = 0; i < 4000; i++) begin
         d = ($urandom % 4 != 0 && m_dcnt < 4) ? pw[12 - 4*m_dcnt +: 4] : 4'($urandom);
         step({$urandom_range(0, 299) != 0, 1'($urandom), d, $urandom % 12 == 0, $urandom % 40 == 0});
         n_cmp++;
         if (dut_v !== exp_v) begin n_err++; $display("FAIL random[%0d]: dut=%b model=%b", i, dut_v, exp_v); end
         n_cmp++;
         if ($countones({unlocked, fail, locked}) > 1) begin
            n_err++;
            $display("FAIL exclusive[%0d]: flags=%b required at most one high", i, {unlocked, fail, locked});
         end
      end
   endtask

   initial begin
      test_reset;
      test_pass;
      test_lockout;
      test_clear;
      test_admin;
      test_ignored;
      test_fail_then_pass;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
